// File: rtl/uart_rx_16x.sv
// 8N1 serial receiver clocked at OVERSAMPLE x baud: two-flop synchronizer, mid-bit sampling FSM,
// and a valid/ready holding register that raises framing-error, break and overrun pulses.
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [BIT_W-1:0]     r_bit;
    logic [BIT_W-1:0]     w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_busy;

    logic                 w_deliver;
    logic                 w_ferr;
    logic                 w_brk;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_ovr;

    // Idle-high reset value keeps the FSM from seeing a phantom start bit right after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_deliver    = 1'b0;
        w_ferr       = 1'b0;
        w_brk        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_MID) begin
                    if (w_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_bit_next   = '0;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    // Right shift: the first (LSB) bit ends up in bit 0 after DATA_BITS samples.
                    w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit == BIT_LAST) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    if (w_rx_s) begin
                        w_deliver    = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (r_shift == '0) begin
                        w_brk        = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The sample counter restarts on every state change and on each completed data bit.
    always_comb begin
        w_cnt_next = '0;
        if ((w_state_next == r_state) && (r_cnt != CNT_LAST) &&
            ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP))) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // A completed byte is taken only if the holding register is empty or being emptied this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_brk  <= w_brk;
            r_ovr  <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign break_det = r_brk;
    assign overrun   = r_ovr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Bench for uart_rx_16x: frames are driven bit by bit, a timestamped event model predicts every
// output cycle by cycle, and directed literal checks pin the key frame timings and byte values.
module tb_uart_rx_16x;

    localparam int OS   = 16;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       break_det;
    logic       overrun;
    logic       busy;

    uart_rx_16x #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .break_det(break_det),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_NONE, EV_BYTE, EV_FERR, EV_BRK} ev_t;

    // Frame outcomes and busy transitions, indexed by the clock edge on which they take effect.
    ev_t        ev_kind [MAXC];
    logic [7:0] ev_data [MAXC];
    bit         ev_on   [MAXC];
    bit         ev_off  [MAXC];

    int         cyc = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_brk   = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int         valid_cycles   = 0;
    int         ferr_cnt       = 0;
    int         brk_cnt        = 0;
    int         ovr_cnt        = 0;
    int         valid_rise_cyc = -1;
    int         ferr_cyc       = -1;
    int         brk_cyc        = -1;
    logic [7:0] last_data      = 8'h00;
    logic       prev_valid     = 1'b0;

    // Reference model: applies the handshake rules to the scheduled frame outcomes at each edge.
    always @(posedge clk) begin
        cyc    = cyc + 1;
        m_ferr = 1'b0;
        m_brk  = 1'b0;
        m_ovr  = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_busy  = 1'b0;
        end else if (cyc < MAXC) begin
            if (ev_kind[cyc] == EV_BYTE) begin
                if (!m_valid || rx_ready) begin
                    m_data  = ev_data[cyc];
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rx_ready) begin
                m_valid = 1'b0;
            end
            if (ev_kind[cyc] == EV_FERR) m_ferr = 1'b1;
            if (ev_kind[cyc] == EV_BRK)  m_brk  = 1'b1;
            if (ev_on[cyc])  m_busy = 1'b1;
            if (ev_off[cyc]) m_busy = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        tick(n);
    endtask

    task automatic sched_on(input int c);
        if (c >= 0 && c < MAXC) ev_on[c] = 1'b1;
    endtask

    task automatic sched_off(input int c);
        if (c >= 0 && c < MAXC) ev_off[c] = 1'b1;
    endtask

    task automatic sched_result(input int c, input ev_t k, input logic [7:0] d);
        if (c >= 0 && c < MAXC) begin
            ev_kind[c] = k;
            ev_data[c] = d;
        end
    endtask

    // Line goes low just after edge e0: FSM busy from e0+3, stop-bit outcome lands on e0+155.
    task automatic sched_frame(input int e0, input logic [7:0] d, input logic stop);
        sched_on(e0 + 3);
        if (stop) begin
            sched_result(e0 + 155, EV_BYTE, d);
            sched_off(e0 + 155);
        end else if (d == 8'h00) begin
            sched_result(e0 + 155, EV_BRK, d);
        end else begin
            sched_result(e0 + 155, EV_FERR, d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        int e0;
        e0 = cyc;
        sched_frame(e0, d, stop);
        drive(1'b0, OS);
        for (int b = 0; b < 8; b++) drive(d[b], OS);
        drive(stop, OS);
    endtask

    // Raising the line out of a held-low condition idles the FSM three edges later.
    task automatic release_line(input bit from_wait, input int n);
        if (from_wait) sched_off(cyc + 3);
        drive(1'b1, n);
    endtask

    initial begin
        int t0;
        int v0;
        int f0;
        int b0;
        int o0;

        for (int i = 0; i < MAXC; i++) begin
            ev_kind[i] = EV_NONE;
            ev_data[i] = 8'h00;
            ev_on[i]   = 1'b0;
            ev_off[i]  = 1'b0;
        end
        rx       = 1'b1;
        rx_ready = 1'b1;
        rst_n    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    check("valid", rx_valid, m_valid);
                    if (m_valid) check("data", rx_data, m_data);
                    check("frame_err", frame_err, m_ferr);
                    check("break_det", break_det, m_brk);
                    check("overrun", overrun, m_ovr);
                    check("busy", busy, m_busy);
                    if (rx_valid) begin
                        valid_cycles++;
                        last_data = rx_data;
                        if (!prev_valid) valid_rise_cyc = cyc;
                    end
                    if (frame_err) begin
                        ferr_cnt++;
                        ferr_cyc = cyc;
                    end
                    if (break_det) begin
                        brk_cnt++;
                        brk_cyc = cyc;
                    end
                    if (overrun) ovr_cnt++;
                    prev_valid = rx_valid;
                end else begin
                    prev_valid = 1'b0;
                end
            end
        join_none

        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_break", break_det, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        drive(1'b1, 10);

        // 0xA5 with consumer always ready.
        t0 = cyc; v0 = valid_cycles; f0 = ferr_cnt + brk_cnt + ovr_cnt;
        send_frame(8'hA5, 1'b1);
        drive(1'b1, 10);
        check("a5_valid_edge", valid_rise_cyc, t0 + 155);
        check("a5_data", last_data, 8'hA5);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_flags", ferr_cnt + brk_cnt + ovr_cnt - f0, 0);
        check("a5_busy_low", busy, 0);

        // Short low glitch rejected at the mid-start check, then 0x3C.
        t0 = cyc; v0 = valid_cycles; f0 = ferr_cnt + brk_cnt + ovr_cnt;
        sched_on(t0 + 3);
        sched_off(t0 + 11);
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_no_flags", ferr_cnt + brk_cnt + ovr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        drive(1'b1, 10);
        check("3c_data", last_data, 8'h3C);

        // 0x81 with a low stop bit, then 0x55.
        t0 = cyc; v0 = valid_cycles; f0 = ferr_cnt; b0 = brk_cnt;
        send_frame(8'h81, 1'b0);
        check("ferr_busy_held", busy, 1);
        release_line(1'b1, 20);
        check("ferr_edge", ferr_cyc, t0 + 155);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_no_break", brk_cnt - b0, 0);
        check("ferr_no_valid", valid_cycles - v0, 0);
        check("ferr_busy_low", busy, 0);
        send_frame(8'h55, 1'b1);
        drive(1'b1, 10);
        check("55_data", last_data, 8'h55);

        // Line held low for 20 bit times.
        t0 = cyc; v0 = valid_cycles; f0 = ferr_cnt; b0 = brk_cnt;
        sched_frame(t0, 8'h00, 1'b0);
        drive(1'b0, 20 * OS);
        check("brk_busy_held", busy, 1);
        release_line(1'b1, 20);
        check("brk_edge", brk_cyc, t0 + 155);
        check("brk_pulses", brk_cnt - b0, 1);
        check("brk_no_ferr", ferr_cnt - f0, 0);
        check("brk_no_valid", valid_cycles - v0, 0);
        check("brk_busy_low", busy, 0);

        // 0x11 then 0x22 with no consumer: second byte dropped.
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        drive(1'b1, 4);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        drive(1'b1, 4);
        check("ovr_accepted", rx_valid, 0);

        // Same pair, ready asserted exactly on the 0x22 delivery edge (fork time + 160 + 155).
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                tick(314);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        drive(1'b1, 4);
        check("swap_data", rx_data, 8'h22);
        check("swap_valid", rx_valid, 1);
        check("swap_no_ovr", ovr_cnt - o0, 0);

        // Reset during data bit 3 of 0xF0 while 0x22 is still held.
        t0 = cyc;
        sched_on(t0 + 3);
        drive(1'b0, OS);
        for (int b = 0; b < 3; b++) drive(1'b0, OS);
        drive(1'b0, 8);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", rx_valid, 0);
        check("arst_data", rx_data, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_break", break_det, 0);
        check("arst_overrun", overrun, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        drive(1'b1, 10);
        check("post_rst_valid", rx_valid, 0);
        send_frame(8'h0F, 1'b1);
        drive(1'b1, 4);
        check("0f_data", rx_data, 8'h0F);
        check("0f_valid", rx_valid, 1);
        rx_ready = 1'b1;
        drive(1'b1, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
